// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl_pkg
// Brief    : Shared encodings for the memory bus controller: FSM states,
//            request channel ids, the abort fault word and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_ctrl_pkg;

    // FSM state encodings
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ISSUE = 1'b1;

    // Request channel ids
    localparam logic [1:0] c_CH_FETCH = 2'd0;
    localparam logic [1:0] c_CH_LOAD  = 2'd1;
    localparam logic [1:0] c_CH_STORE = 2'd2;

    // Word returned to a read that was aborted by the bus timeout
    localparam logic [31:0] c_FAULT_WORD = 32'hDEAD_BEEF;

    // Fixed priority: store > load > fetch. Fetch is the fall-through, so
    // only the two higher-priority pending flags need to be looked at.
    function automatic logic [1:0] pick_channel(input logic store_pend,
                                                input logic load_pend);
        if (store_pend) begin
            return c_CH_STORE;
        end else if (load_pend) begin
            return c_CH_LOAD;
        end
        return c_CH_FETCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_detect.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_detect
// Brief    : Per-channel new-request detector plus pending slot. A request
//            is new when en rises or addr/data change while en is high. The
//            slot is overwritten by newer requests except while the channel
//            is locked by the bus FSM; then the newcomer waits in a shadow.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_detect #(
    parameter int AW = 32,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_data,
    input  logic          i_lock,
    input  logic          i_clear,
    output logic          o_detect,
    output logic          o_pending,
    output logic [AW-1:0] o_addr,
    output logic [W-1:0]  o_data
);

    logic          r_en_prev;
    logic [AW-1:0] r_addr_prev;
    logic [W-1:0]  r_data_prev;
    logic          r_pending;
    logic [AW-1:0] r_addr;
    logic [W-1:0]  r_data;
    logic          r_sh_valid;
    logic [AW-1:0] r_sh_addr;
    logic [W-1:0]  r_sh_data;

    assign o_detect  = i_en && (!r_en_prev || (i_addr != r_addr_prev) ||
                                (i_data != r_data_prev));
    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_data    = r_data;

    // Remember last cycle's request inputs for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_prev   <= 1'b0;
            r_addr_prev <= '0;
            r_data_prev <= '0;
        end else begin
            r_en_prev   <= i_en;
            r_addr_prev <= i_addr;
            r_data_prev <= i_data;
        end
    end

    // Pending slot and one-deep shadow; a completion promotes the newest request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sh_valid <= 1'b0;
            r_sh_addr  <= '0;
            r_sh_data  <= '0;
        end else if (i_clear) begin
            r_sh_valid <= 1'b0;
            if (o_detect) begin
                r_pending <= 1'b1;
                r_addr    <= i_addr;
                r_data    <= i_data;
            end else if (r_sh_valid) begin
                r_pending <= 1'b1;
                r_addr    <= r_sh_addr;
                r_data    <= r_sh_data;
            end else begin
                r_pending <= 1'b0;
            end
        end else if (o_detect) begin
            if (i_lock) begin
                r_sh_valid <= 1'b1;
                r_sh_addr  <= i_addr;
                r_sh_data  <= i_data;
            end else begin
                r_pending <= 1'b1;
                r_addr    <= i_addr;
                r_data    <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Brief    : Serialises cpu fetch/load/store requests onto a single word-wide
//            req/ack memory bus (priority store > load > fetch) and returns
//            registered, held read data.
// Options  : MEM_CTRL_TIMEOUT_EN - abort a transfer with no ack after
//            TIMEOUT_CYCLES request cycles and raise the sticky bus_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int W              = 32,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_en,
    input  logic [AW-1:0] pc,
    output logic [W-1:0]  read_inst,
    input  logic          load_en,
    input  logic [AW-1:0] l_addr,
    output logic [W-1:0]  l_data,
    input  logic          store_en,
    input  logic [AW-1:0] s_addr,
    input  logic [W-1:0]  s_data,
    output logic          mem_busy,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [W-1:0]  bus_wdata,
    input  logic [W-1:0]  bus_rdata,
    input  logic          bus_ack,
    output logic          bus_err
);

    logic [0:0]    r_state;
    logic [1:0]    r_ch;

    logic          w_det_f, w_det_l, w_det_s;
    logic          w_pend_f, w_pend_l, w_pend_s;
    logic [AW-1:0] w_addr_f, w_addr_l, w_addr_s;
    logic [W-1:0]  w_data_f, w_data_l, w_data_s;
    logic          w_any_pend;
    logic [1:0]    w_sel;
    logic          w_grant_idle;
    logic          w_issue;
    logic          w_done;
    logic [AW-1:0] w_sel_addr;
    logic [W-1:0]  w_sel_data;

    assign w_any_pend   = w_pend_f | w_pend_l | w_pend_s;
    assign w_sel        = pick_channel(w_pend_s, w_pend_l);
    assign w_grant_idle = (r_state == c_ST_IDLE) && w_any_pend;
    assign w_issue      = (r_state == c_ST_ISSUE);
    assign mem_busy     = w_any_pend | w_issue | w_det_f | w_det_l | w_det_s;

    // Fetch and load carry no data; their data path is tied off to zero.
    mem_req_detect #(.AW(AW), .W(W)) u_fetch (
        .clk(clk), .rst(rst), .i_en(pc_en), .i_addr(pc), .i_data('0),
        .i_lock((w_grant_idle && w_sel == c_CH_FETCH) || (w_issue && r_ch == c_CH_FETCH)),
        .i_clear(w_done && r_ch == c_CH_FETCH),
        .o_detect(w_det_f), .o_pending(w_pend_f), .o_addr(w_addr_f), .o_data(w_data_f)
    );

    mem_req_detect #(.AW(AW), .W(W)) u_load (
        .clk(clk), .rst(rst), .i_en(load_en), .i_addr(l_addr), .i_data('0),
        .i_lock((w_grant_idle && w_sel == c_CH_LOAD) || (w_issue && r_ch == c_CH_LOAD)),
        .i_clear(w_done && r_ch == c_CH_LOAD),
        .o_detect(w_det_l), .o_pending(w_pend_l), .o_addr(w_addr_l), .o_data(w_data_l)
    );

    mem_req_detect #(.AW(AW), .W(W)) u_store (
        .clk(clk), .rst(rst), .i_en(store_en), .i_addr(s_addr), .i_data(s_data),
        .i_lock((w_grant_idle && w_sel == c_CH_STORE) || (w_issue && r_ch == c_CH_STORE)),
        .i_clear(w_done && r_ch == c_CH_STORE),
        .o_detect(w_det_s), .o_pending(w_pend_s), .o_addr(w_addr_s), .o_data(w_data_s)
    );

    // Route the granted slot's address and data towards the bus registers
    always_comb begin
        w_sel_addr = w_addr_f;
        w_sel_data = w_data_f;
        case (w_sel)
            c_CH_LOAD: begin
                w_sel_addr = w_addr_l;
                w_sel_data = w_data_l;
            end
            c_CH_STORE: begin
                w_sel_addr = w_addr_s;
                w_sel_data = w_data_s;
            end
            default: begin
                w_sel_addr = w_addr_f;
                w_sel_data = w_data_f;
            end
        endcase
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TW-1:0] r_timer;
    logic            w_timeout;

    assign w_timeout = w_issue && !bus_ack && (r_timer == c_TW'(TIMEOUT_CYCLES - 1));
    assign w_done    = w_issue && (bus_ack || w_timeout);

    // Count request cycles of the current transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_issue && !w_done) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (w_timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign w_done  = w_issue && bus_ack;
    assign bus_err = 1'b0;
`endif

    // Bus FSM: grant a slot from IDLE, hold the bus in ISSUE until completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_ch      <= c_CH_FETCH;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            read_inst <= '0;
            l_data    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_pend) begin
                        r_ch      <= w_sel;
                        bus_req   <= 1'b1;
                        bus_we    <= (w_sel == c_CH_STORE);
                        bus_addr  <= {w_sel_addr[AW-1:2], 2'b00};
                        bus_wdata <= w_sel_data;
                        r_state   <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_state <= c_ST_IDLE;
                        if (!bus_we) begin
                            if (r_ch == c_CH_FETCH) begin
                                read_inst <= bus_rdata;
                            end else if (r_ch == c_CH_LOAD) begin
                                l_data <= bus_rdata;
                            end
                        end
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                    else if (w_timeout) begin
                        bus_req <= 1'b0;
                        r_state <= c_ST_IDLE;
                        if (!bus_we) begin
                            if (r_ch == c_CH_FETCH) begin
                                read_inst <= W'(c_FAULT_WORD);
                            end else if (r_ch == c_CH_LOAD) begin
                                l_data <= W'(c_FAULT_WORD);
                            end
                        end
                    end
`endif
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_ctrl
// Brief    : Self-checking bench for mem_bus_ctrl. A bus responder with a
//            word memory and programmable ack delay serves the DUT; a queue
//            of expected transfers plus held-value model is compared every
//            cycle, alongside hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int c_W  = 32;
    localparam int c_AW = 32;
`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int c_TO = 4;
`endif

    logic            clk;
    logic            rst;
    logic            pc_en;
    logic [c_AW-1:0] pc;
    logic [c_W-1:0]  read_inst;
    logic            load_en;
    logic [c_AW-1:0] l_addr;
    logic [c_W-1:0]  l_data;
    logic            store_en;
    logic [c_AW-1:0] s_addr;
    logic [c_W-1:0]  s_data;
    logic            mem_busy;
    logic            bus_req;
    logic            bus_we;
    logic [c_AW-1:0] bus_addr;
    logic [c_W-1:0]  bus_wdata;
    logic [c_W-1:0]  bus_rdata;
    logic            bus_ack;
    logic            bus_err;

    mem_bus_ctrl #(
        .W(c_W),
        .AW(c_AW)
`ifdef MEM_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(c_TO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .pc_en(pc_en), .pc(pc), .read_inst(read_inst),
        .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
        .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
        .mem_busy(mem_busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder (memory) ----------------
    bit [31:0] mem [bit [31:0]];
    int        ack_delay = 0;
    int        wait_cnt  = 0;

    always @(negedge clk) begin
        if (bus_req === 1'b1 && rst === 1'b0) begin
            if (wait_cnt == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
                if (bus_we) mem[bus_addr] = bus_wdata;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 32'h0;
            end
            wait_cnt++;
        end else begin
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            wait_cnt  = 0;
        end
    end

    // ---------------- behavioural model ----------------
    // ch: 0 fetch, 1 load, 2 store
    typedef struct {
        int        ch;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
    } txn_t;

    txn_t      q[$];
    txn_t      cur;
    bit        in_txn   = 1'b0;
    bit        prev_req = 1'b0;
    bit [31:0] exp_ri   = 32'h0;
    bit [31:0] exp_ld   = 32'h0;
    bit        exp_err  = 1'b0;
    int        txn_cycles = 0;
    int        n_reads    = 0;
    int        n_issues   = 0;
    int        req_cycles = 0;

    task automatic push(input int ch, input bit we, input bit [31:0] a, input bit [31:0] d);
        txn_t t;
        t.ch = ch; t.we = we; t.addr = a; t.wdata = d;
        q.push_back(t);
    endtask

    // Completion: at the sampling edge the transfer ends and read data lands
    always @(posedge clk) begin
        if (rst === 1'b0 && in_txn) begin
            if (bus_req === 1'b1) req_cycles++;
            txn_cycles++;
            if (bus_req === 1'b1 && bus_ack === 1'b1) begin
                if (!cur.we) begin
                    n_reads++;
                    if (cur.ch == 0) exp_ri = mem.exists(cur.addr) ? mem[cur.addr] : 32'h0;
                    else             exp_ld = mem.exists(cur.addr) ? mem[cur.addr] : 32'h0;
                end
                in_txn = 1'b0;
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            else if (txn_cycles == c_TO) begin
                if (!cur.we) begin
                    if (cur.ch == 0) exp_ri = 32'hDEAD_BEEF;
                    else             exp_ld = 32'hDEAD_BEEF;
                end
                exp_err = 1'b1;
                in_txn  = 1'b0;
            end
`endif
        end
    end

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            q.delete();
            in_txn   = 1'b0;
            prev_req = 1'b0;
            exp_ri   = 32'h0;
            exp_ld   = 32'h0;
            exp_err  = 1'b0;
        end else begin
            if (bus_req === 1'b1 && !in_txn) begin
                check("idle_gap", prev_req, 1'b0);
                n_issues++;
                txn_cycles = 0;
                in_txn = 1'b1;
                if (q.size() == 0) begin
                    check("unexpected_req", bus_req, 1'b0);
                    cur.ch = -1; cur.we = bus_we; cur.addr = bus_addr; cur.wdata = bus_wdata;
                end else begin
                    cur = q.pop_front();
                    check("issue_we", bus_we, cur.we);
                    check("issue_addr", bus_addr, cur.addr);
                    if (cur.we) check("issue_wdata", bus_wdata, cur.wdata);
                end
            end else if (bus_req === 1'b1) begin
                check("hold_we", bus_we, cur.we);
                check("hold_addr", bus_addr, cur.addr);
                if (cur.we) check("hold_wdata", bus_wdata, cur.wdata);
            end
            check("read_inst", read_inst, exp_ri);
            check("l_data", l_data, exp_ld);
            check("mem_busy", mem_busy, (q.size() != 0) || in_txn);
            check("bus_err", bus_err, exp_err);
            prev_req = bus_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (mem_busy !== 1'b0 && k < max) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_idle", mem_busy, 1'b0);
    endtask

    initial begin
        int r0;
        int k;
        rst = 1'b1;
        pc_en = 1'b0; pc = '0; load_en = 1'b0; l_addr = '0;
        store_en = 1'b0; s_addr = '0; s_data = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        mem[32'h40]  = 32'h2408_0005;
        mem[32'h100] = 32'h1111_1111;
        mem[32'h8]   = 32'hCAFE_0008;
        mem[32'h200] = 32'h0BAD_F00D;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_read_inst", read_inst, 32'h0);
        check("rst_l_data", l_data, 32'h0);
        check("rst_mem_busy", mem_busy, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;

        // 1: single fetch, zero wait states
        @(posedge clk); #1;
        pc = 32'h40; pc_en = 1'b1; push(0, 1'b0, 32'h40, 32'h0);
        @(posedge clk); #1;          // edge N
        pc_en = 1'b0;
        check("t1_req_N", bus_req, 1'b0);
        @(posedge clk); #1;          // edge N+1
        check("t1_req_N1", bus_req, 1'b1);
        check("t1_addr_N1", bus_addr, 32'h40);
        @(posedge clk); #1;          // edge N+2
        check("t1_inst_N2", read_inst, 32'h2408_0005);
        check("t1_busy_N2", mem_busy, 1'b0);

        // 2: simultaneous store and load to the same address
        @(posedge clk); #1;
        l_addr = 32'h100; load_en = 1'b1;
        s_addr = 32'h100; s_data = 32'hA5A5_A5A5; store_en = 1'b1;
        push(2, 1'b1, 32'h100, 32'hA5A5_A5A5);
        push(1, 1'b0, 32'h100, 32'h0);
        @(posedge clk); #1;
        load_en = 1'b0; store_en = 1'b0;
        wait_idle(50);
        check("t2_l_data", l_data, 32'hA5A5_A5A5);

        // 3: held fetch enable with constant pc issues exactly once
        r0 = n_reads;
        @(posedge clk); #1;
        pc = 32'h8; pc_en = 1'b1; push(0, 1'b0, 32'h8, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("t3_busy_low", mem_busy, 1'b0);
        check("t3_one_read", n_reads - r0, 1);
        check("t3_inst", read_inst, 32'hCAFE_0008);
        pc_en = 1'b0;

        // 4: ack delayed 7 cycles
        ack_delay = 7;
        r0 = req_cycles;
        @(posedge clk); #1;
        l_addr = 32'h200; load_en = 1'b1; push(1, 1'b0, 32'h200, 32'h0);
        @(posedge clk); #1;
        load_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t4_l_data_held", l_data, 32'hA5A5_A5A5);
        check("t4_busy_mid", mem_busy, 1'b1);
        wait_idle(40);
        check("t4_l_data", l_data, 32'h0BAD_F00D);
        check("t4_req_cycles", req_cycles - r0, 8);
        ack_delay = 0;

        // 5: asynchronous reset in the middle of a transfer
        ack_delay = 20;
        @(posedge clk); #1;
        pc = 32'h300; pc_en = 1'b1; push(0, 1'b0, 32'h300, 32'h0);
        @(posedge clk); #1;
        pc_en = 1'b0;
        k = 0;
        while (bus_req !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_req_seen", bus_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_req_drop", bus_req, 1'b0);
        check("t5_inst_clr", read_inst, 32'h0);
        check("t5_ldata_clr", l_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = n_issues;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_reissue", n_issues - r0, 0);
        check("t5_busy", mem_busy, 1'b0);
        ack_delay = 0;

`ifdef MEM_CTRL_TIMEOUT_EN
        // 6: no ack -> abort after the timeout
        ack_delay = 100;
        @(posedge clk); #1;
        pc = 32'h600; pc_en = 1'b1; push(0, 1'b0, 32'h600, 32'h0);
        @(posedge clk); #1;
        pc_en = 1'b0;
        wait_idle(30);
        check("t6_inst", read_inst, 32'hDEAD_BEEF);
        check("t6_err", bus_err, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_sticky", bus_err, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_err_clr", bus_err, 1'b0);
        ack_delay = 0;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
